// File: rtl/itlb_refill.sv
// ITLB miss-handling and refill controller.
// Accepts one miss, issues a PTW walk request, and on a good response writes
// a single ITLB entry chosen invalid-first, then round-robin.
module itlb_refill #(
    parameter int ENTRIES = 8,
    parameter int ASID_WD = 9,
    parameter int VPN_WD  = 20,
    parameter int PPN_WD  = 22
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tlb_flush_i,
    input  logic               miss_valid_i,
    output logic               miss_ready_o,
    input  logic [ASID_WD-1:0] miss_asid_i,
    input  logic [VPN_WD-1:0]  miss_vpn_i,
    output logic               ptw_req_valid_o,
    input  logic               ptw_req_ready_i,
    output logic [ASID_WD-1:0] ptw_req_asid_o,
    output logic [VPN_WD-1:0]  ptw_req_vpn_o,
    input  logic               ptw_rsp_valid_i,
    input  logic               ptw_rsp_fault_i,
    input  logic               ptw_rsp_g_i,
    input  logic [PPN_WD-1:0]  ptw_rsp_ppn_i,
    input  logic [ENTRIES-1:0] entry_valid_i,
    output logic [ENTRIES-1:0] entry_we_o,
    output logic [ASID_WD-1:0] entry_asid_o,
    output logic [VPN_WD-1:0]  entry_vpn_o,
    output logic               entry_g_o,
    output logic [PPN_WD-1:0]  entry_ppn_o,
    output logic               refill_done_o,
    output logic               refill_fault_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WRITE,
        ST_DRAIN
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   rr_q;
    logic [ASID_WD-1:0] asid_q;
    logic [VPN_WD-1:0]  vpn_q;
    logic               g_q;
    logic [PPN_WD-1:0]  ppn_q;
    logic               fault_q;

    logic               accept;
    logic               rsp_take;
    logic               fault_set;
    logic               write_fire;
    logic [IDX_W-1:0]   victim;
    logic               victim_is_rr;

    // State register; reset always lands in IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured request/response fields, fault pulse and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            asid_q  <= '0;
            vpn_q   <= '0;
            g_q     <= 1'b0;
            ppn_q   <= '0;
            fault_q <= 1'b0;
            rr_q    <= '0;
        end else begin
            if (accept) begin
                asid_q <= miss_asid_i;
                vpn_q  <= miss_vpn_i;
            end
            if (rsp_take) begin
                g_q   <= ptw_rsp_g_i;
                ppn_q <= ptw_rsp_ppn_i;
            end
            // Fault is reported the cycle after the response, already in IDLE.
            fault_q <= fault_set;
            // Pointer only advances when the round-robin victim is actually used.
            if (write_fire && victim_is_rr) begin
                rr_q <= rr_q + IDX_W'(1);
            end
        end
    end

    // Victim: lowest-index invalid entry, otherwise the round-robin pointer.
    always_comb begin
        victim       = rr_q;
        victim_is_rr = 1'b1;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!entry_valid_i[i]) begin
                victim       = IDX_W'(i);
                victim_is_rr = 1'b0;
            end
        end
    end

    // Next-state decode and state-dependent outputs.
    always_comb begin
        state_d         = state_q;
        accept          = 1'b0;
        rsp_take        = 1'b0;
        fault_set       = 1'b0;
        write_fire      = 1'b0;
        miss_ready_o    = 1'b0;
        ptw_req_valid_o = 1'b0;
        ptw_req_asid_o  = '0;
        ptw_req_vpn_o   = '0;
        entry_we_o      = '0;
        entry_asid_o    = '0;
        entry_vpn_o     = '0;
        entry_g_o       = 1'b0;
        entry_ppn_o     = '0;
        refill_done_o   = 1'b0;
        refill_fault_o  = 1'b0;

        if (rst_i) begin
            // Outputs show the idle/reset view while reset is held.
            miss_ready_o = 1'b1;
        end else begin
            refill_fault_o = fault_q;
            case (state_q)
                ST_IDLE: begin
                    miss_ready_o = 1'b1;
                    if (miss_valid_i && !tlb_flush_i) begin
                        accept  = 1'b1;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    ptw_req_valid_o = 1'b1;
                    ptw_req_asid_o  = asid_q;
                    ptw_req_vpn_o   = vpn_q;
                    if (ptw_req_ready_i) begin
                        // A flush after the handshake still owes us a response.
                        state_d = tlb_flush_i ? ST_DRAIN : ST_WAIT;
                    end else if (tlb_flush_i) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (ptw_rsp_valid_i) begin
                        state_d = ST_IDLE;
                        if (!tlb_flush_i) begin
                            if (ptw_rsp_fault_i) begin
                                fault_set = 1'b1;
                            end else begin
                                rsp_take = 1'b1;
                                state_d  = ST_WRITE;
                            end
                        end
                    end else if (tlb_flush_i) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_WRITE: begin
                    // Flush wins over the write in this cycle.
                    write_fire         = !tlb_flush_i;
                    entry_we_o[victim] = write_fire;
                    entry_asid_o       = asid_q;
                    entry_vpn_o        = vpn_q;
                    entry_g_o          = g_q;
                    entry_ppn_o        = ppn_q;
                    refill_done_o      = write_fire;
                    state_d            = ST_IDLE;
                end
                ST_DRAIN: begin
                    if (ptw_rsp_valid_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_itlb_refill.sv
// Self-checking bench for itlb_refill: scoreboard of expected entry writes
// plus per-scenario cycle checks.
module tb_itlb_refill;

    localparam int ENTRIES = 8;
    localparam int ASID_WD = 9;
    localparam int VPN_WD  = 20;
    localparam int PPN_WD  = 22;

    logic               clk_i;
    logic               rst_i;
    logic               tlb_flush_i;
    logic               miss_valid_i;
    logic               miss_ready_o;
    logic [ASID_WD-1:0] miss_asid_i;
    logic [VPN_WD-1:0]  miss_vpn_i;
    logic               ptw_req_valid_o;
    logic               ptw_req_ready_i;
    logic [ASID_WD-1:0] ptw_req_asid_o;
    logic [VPN_WD-1:0]  ptw_req_vpn_o;
    logic               ptw_rsp_valid_i;
    logic               ptw_rsp_fault_i;
    logic               ptw_rsp_g_i;
    logic [PPN_WD-1:0]  ptw_rsp_ppn_i;
    logic [ENTRIES-1:0] entry_valid_i;
    logic [ENTRIES-1:0] entry_we_o;
    logic [ASID_WD-1:0] entry_asid_o;
    logic [VPN_WD-1:0]  entry_vpn_o;
    logic               entry_g_o;
    logic [PPN_WD-1:0]  entry_ppn_o;
    logic               refill_done_o;
    logic               refill_fault_o;

    itlb_refill #(
        .ENTRIES(ENTRIES), .ASID_WD(ASID_WD), .VPN_WD(VPN_WD), .PPN_WD(PPN_WD)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .tlb_flush_i(tlb_flush_i),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
        .miss_asid_i(miss_asid_i), .miss_vpn_i(miss_vpn_i),
        .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
        .ptw_req_asid_o(ptw_req_asid_o), .ptw_req_vpn_o(ptw_req_vpn_o),
        .ptw_rsp_valid_i(ptw_rsp_valid_i), .ptw_rsp_fault_i(ptw_rsp_fault_i),
        .ptw_rsp_g_i(ptw_rsp_g_i), .ptw_rsp_ppn_i(ptw_rsp_ppn_i),
        .entry_valid_i(entry_valid_i), .entry_we_o(entry_we_o),
        .entry_asid_o(entry_asid_o), .entry_vpn_o(entry_vpn_o),
        .entry_g_o(entry_g_o), .entry_ppn_o(entry_ppn_o),
        .refill_done_o(refill_done_o), .refill_fault_o(refill_fault_o)
    );

    typedef struct packed {
        logic [ENTRIES-1:0] we;
        logic [ASID_WD-1:0] asid;
        logic [VPN_WD-1:0]  vpn;
        logic               g;
        logic [PPN_WD-1:0]  ppn;
    } wr_t;

    wr_t                sb_q[$];
    wr_t                mon_exp;
    logic [ENTRIES-1:0] last_we;
    logic [2:0]         rr_m;
    int                 n_checks;
    int                 n_fails;

    logic [92:0] all_out;
    assign all_out = {miss_ready_o, ptw_req_valid_o, ptw_req_asid_o, ptw_req_vpn_o,
                      entry_we_o, entry_asid_o, entry_vpn_o, entry_g_o, entry_ppn_o,
                      refill_done_o, refill_fault_o};
    localparam logic [92:0] RESET_OUT = {1'b1, 92'b0};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Scoreboard monitor: every observed write must match the oldest expectation.
    always @(negedge clk_i) begin
        if (entry_we_o !== '0 || refill_done_o !== 1'b0) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_write: we=%h done=%b, required no write", entry_we_o, refill_done_o);
            end else begin
                mon_exp = sb_q.pop_front();
                last_we = entry_we_o;
                if ({entry_we_o, entry_asid_o, entry_vpn_o, entry_g_o, entry_ppn_o, refill_done_o}
                    !== {mon_exp, 1'b1}) begin
                    n_fails++;
                    $display("FAIL sb_write: got we=%h asid=%h vpn=%h g=%b ppn=%h done=%b, required we=%h asid=%h vpn=%h g=%b ppn=%h done=1",
                             entry_we_o, entry_asid_o, entry_vpn_o, entry_g_o, entry_ppn_o, refill_done_o,
                             mon_exp.we, mon_exp.asid, mon_exp.vpn, mon_exp.g, mon_exp.ppn);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Expected write for a good response: invalid-first, else round-robin.
    task automatic push_exp(input logic [ASID_WD-1:0] asid, input logic [VPN_WD-1:0] vpn,
                            input logic [PPN_WD-1:0] ppn, input logic g,
                            input logic [ENTRIES-1:0] valid);
        wr_t e;
        logic found;
        found = 1'b0;
        e.we = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!found && !valid[i]) begin
                e.we[i] = 1'b1;
                found   = 1'b1;
            end
        end
        if (!found) begin
            e.we[rr_m] = 1'b1;
            rr_m = rr_m + 3'd1;
        end
        e.asid = asid;
        e.vpn  = vpn;
        e.g    = g;
        e.ppn  = ppn;
        sb_q.push_back(e);
    endtask

    // Drives one complete miss/walk/response with a ready PTW; writes are checked by the monitor.
    task automatic run_refill(input logic [ASID_WD-1:0] asid, input logic [VPN_WD-1:0] vpn,
                              input logic [PPN_WD-1:0] ppn, input logic g,
                              input logic [ENTRIES-1:0] valid);
        entry_valid_i = valid;
        miss_valid_i  = 1'b1;
        miss_asid_i   = asid;
        miss_vpn_i    = vpn;
        cyc();
        miss_valid_i  = 1'b0;
        cyc();
        ptw_rsp_valid_i = 1'b1;
        ptw_rsp_ppn_i   = ppn;
        ptw_rsp_g_i     = g;
        push_exp(asid, vpn, ppn, g, valid);
        cyc();
        ptw_rsp_valid_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cyc();
        cyc();
        @(negedge clk_i);
        n_checks++;
        if (all_out !== RESET_OUT) begin
            n_fails++;
            $display("FAIL reset_outputs: got %h, required %h", all_out, RESET_OUT);
        end
        cyc();
        rst_i = 1'b0;
        rr_m  = 3'd0;
    endtask

    task automatic test_basic();
        entry_valid_i = '0;
        miss_valid_i  = 1'b1;
        miss_asid_i   = 9'h005;
        miss_vpn_i    = 20'h12345;
        @(negedge clk_i);
        n_checks++;
        if (miss_ready_o !== 1'b1) begin
            n_fails++;
            $display("FAIL basic_ready_idle: got %b, required 1", miss_ready_o);
        end
        cyc();
        miss_valid_i = 1'b0;
        miss_asid_i  = '0;
        miss_vpn_i   = '0;
        @(negedge clk_i);
        n_checks++;
        if ({ptw_req_valid_o, ptw_req_asid_o, ptw_req_vpn_o, miss_ready_o} !== {1'b1, 9'h005, 20'h12345, 1'b0}) begin
            n_fails++;
            $display("FAIL basic_req: got valid=%b asid=%h vpn=%h ready=%b, required valid=1 asid=005 vpn=12345 ready=0",
                     ptw_req_valid_o, ptw_req_asid_o, ptw_req_vpn_o, miss_ready_o);
        end
        cyc();
        ptw_rsp_valid_i = 1'b1;
        ptw_rsp_ppn_i   = 22'h0ABCD;
        ptw_rsp_g_i     = 1'b0;
        push_exp(9'h005, 20'h12345, 22'h0ABCD, 1'b0, entry_valid_i);
        @(negedge clk_i);
        n_checks++;
        if ({ptw_req_valid_o, entry_we_o, refill_done_o} !== '0) begin
            n_fails++;
            $display("FAIL basic_wait: got req_valid=%b we=%h done=%b, required all 0", ptw_req_valid_o, entry_we_o, refill_done_o);
        end
        cyc();
        ptw_rsp_valid_i = 1'b0;
        ptw_rsp_ppn_i   = '0;
        @(negedge clk_i);
        n_checks++;
        if ({entry_we_o, entry_asid_o, entry_vpn_o, entry_ppn_o, refill_done_o} !==
            {8'h01, 9'h005, 20'h12345, 22'h0ABCD, 1'b1}) begin
            n_fails++;
            $display("FAIL basic_write_c3: got we=%h asid=%h vpn=%h ppn=%h done=%b, required we=01 asid=005 vpn=12345 ppn=00abcd done=1",
                     entry_we_o, entry_asid_o, entry_vpn_o, entry_ppn_o, refill_done_o);
        end
        cyc();
        @(negedge clk_i);
        n_checks++;
        if ({entry_we_o, refill_done_o, miss_ready_o} !== {8'h00, 1'b0, 1'b1}) begin
            n_fails++;
            $display("FAIL basic_after: got we=%h done=%b ready=%b, required we=00 done=0 ready=1", entry_we_o, refill_done_o, miss_ready_o);
        end
        cyc();
    endtask

    task automatic test_victim_order();
        last_we = '0;
        run_refill(9'h011, 20'h00100, 22'h00200, 1'b1, 8'b1111_0111);
        n_checks++;
        if (last_we !== 8'h08) begin
            n_fails++;
            $display("FAIL victim_invalid_first: got we=%h, required 08", last_we);
        end
        for (int k = 0; k < 8; k++) begin
            last_we = '0;
            run_refill(9'(k), 20'h40000 + 20'(k), 22'h10000 + 22'(k), k[0], 8'hFF);
        end
        n_checks++;
        if (last_we !== 8'h80) begin
            n_fails++;
            $display("FAIL victim_rr7: got we=%h, required 80", last_we);
        end
        last_we = '0;
        run_refill(9'h0AA, 20'hABCDE, 22'h3FFFFF, 1'b0, 8'hFF);
        n_checks++;
        if (last_we !== 8'h01) begin
            n_fails++;
            $display("FAIL victim_rr_wrap: got we=%h, required 01", last_we);
        end
    endtask

    task automatic test_fault();
        entry_valid_i = '0;
        miss_valid_i  = 1'b1;
        miss_asid_i   = 9'h033;
        miss_vpn_i    = 20'h0F0F0;
        cyc();
        miss_valid_i  = 1'b0;
        cyc();
        ptw_rsp_valid_i = 1'b1;
        ptw_rsp_fault_i = 1'b1;
        cyc();
        ptw_rsp_valid_i = 1'b0;
        ptw_rsp_fault_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({refill_fault_o, entry_we_o, refill_done_o, miss_ready_o} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
            n_fails++;
            $display("FAIL fault_pulse: got fault=%b we=%h done=%b ready=%b, required fault=1 we=00 done=0 ready=1",
                     refill_fault_o, entry_we_o, refill_done_o, miss_ready_o);
        end
        cyc();
        @(negedge clk_i);
        n_checks++;
        if (refill_fault_o !== 1'b0) begin
            n_fails++;
            $display("FAIL fault_one_cycle: got %b, required 0", refill_fault_o);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        entry_valid_i   = '0;
        ptw_req_ready_i = 1'b0;
        miss_valid_i    = 1'b1;
        miss_asid_i     = 9'h1A5;
        miss_vpn_i      = 20'hFEDCB;
        cyc();
        miss_valid_i = 1'b0;
        miss_asid_i  = 9'h000;
        miss_vpn_i   = 20'h11111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            n_checks++;
            if ({ptw_req_valid_o, ptw_req_asid_o, ptw_req_vpn_o} !== {1'b1, 9'h1A5, 20'hFEDCB}) begin
                n_fails++;
                $display("FAIL bp_hold%0d: got valid=%b asid=%h vpn=%h, required valid=1 asid=1a5 vpn=fedcb",
                         k, ptw_req_valid_o, ptw_req_asid_o, ptw_req_vpn_o);
            end
            cyc();
        end
        ptw_req_ready_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (ptw_req_valid_o !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_handshake: got valid=%b, required 1", ptw_req_valid_o);
        end
        cyc();
        ptw_rsp_valid_i = 1'b1;
        ptw_rsp_ppn_i   = 22'h2468A;
        ptw_rsp_g_i     = 1'b1;
        push_exp(9'h1A5, 20'hFEDCB, 22'h2468A, 1'b1, entry_valid_i);
        @(negedge clk_i);
        n_checks++;
        if ({ptw_req_valid_o, miss_ready_o} !== 2'b00) begin
            n_fails++;
            $display("FAIL bp_wait: got valid=%b ready=%b, required 0 0", ptw_req_valid_o, miss_ready_o);
        end
        cyc();
        ptw_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (refill_done_o !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_done: got %b, required 1", refill_done_o);
        end
        cyc();
    endtask

    task automatic test_flush();
        // Flush in IDLE blocks acceptance.
        entry_valid_i = '0;
        tlb_flush_i   = 1'b1;
        miss_valid_i  = 1'b1;
        cyc();
        tlb_flush_i  = 1'b0;
        miss_valid_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({ptw_req_valid_o, miss_ready_o} !== 2'b01) begin
            n_fails++;
            $display("FAIL flush_idle: got req_valid=%b ready=%b, required 0 1", ptw_req_valid_o, miss_ready_o);
        end
        cyc();
        // Flush in REQ before the handshake drops the request.
        ptw_req_ready_i = 1'b0;
        miss_valid_i    = 1'b1;
        cyc();
        miss_valid_i = 1'b0;
        tlb_flush_i  = 1'b1;
        cyc();
        tlb_flush_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({ptw_req_valid_o, miss_ready_o} !== 2'b01) begin
            n_fails++;
            $display("FAIL flush_req: got req_valid=%b ready=%b, required 0 1", ptw_req_valid_o, miss_ready_o);
        end
        cyc();
        ptw_req_ready_i = 1'b1;
        // Flush in WAIT: drain the response three cycles later.
        miss_valid_i = 1'b1;
        cyc();
        miss_valid_i = 1'b0;
        cyc();
        tlb_flush_i = 1'b1;
        cyc();
        tlb_flush_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            n_checks++;
            if (miss_ready_o !== 1'b0) begin
                n_fails++;
                $display("FAIL flush_drain%0d: got ready=%b, required 0", k, miss_ready_o);
            end
            cyc();
        end
        ptw_rsp_valid_i = 1'b1;
        ptw_rsp_ppn_i   = 22'h0DEAD;
        cyc();
        ptw_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({miss_ready_o, entry_we_o, refill_done_o, refill_fault_o} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL flush_wait_done: got ready=%b we=%h done=%b fault=%b, required 1 00 0 0",
                     miss_ready_o, entry_we_o, refill_done_o, refill_fault_o);
        end
        cyc();
        // Flush coinciding with WRITE; rr must be left alone.
        entry_valid_i = 8'hFF;
        miss_valid_i  = 1'b1;
        cyc();
        miss_valid_i = 1'b0;
        cyc();
        ptw_rsp_valid_i = 1'b1;
        cyc();
        ptw_rsp_valid_i = 1'b0;
        tlb_flush_i     = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if ({entry_we_o, refill_done_o} !== 9'h000) begin
            n_fails++;
            $display("FAIL flush_write: got we=%h done=%b, required 00 0", entry_we_o, refill_done_o);
        end
        cyc();
        tlb_flush_i = 1'b0;
        last_we = '0;
        run_refill(9'h077, 20'h77777, 22'h07777, 1'b0, 8'hFF);
        n_checks++;
        if (last_we !== 8'h02) begin
            n_fails++;
            $display("FAIL flush_rr_kept: got we=%h, required 02", last_we);
        end
    endtask

    task automatic test_reset_midwalk();
        entry_valid_i = 8'hFF;
        miss_valid_i  = 1'b1;
        cyc();
        miss_valid_i = 1'b0;
        cyc();
        rst_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (all_out !== RESET_OUT) begin
            n_fails++;
            $display("FAIL rst_mid_during: got %h, required %h", all_out, RESET_OUT);
        end
        cyc();
        rst_i = 1'b0;
        rr_m  = 3'd0;
        @(negedge clk_i);
        n_checks++;
        if (all_out !== RESET_OUT) begin
            n_fails++;
            $display("FAIL rst_mid_idle: got %h, required %h", all_out, RESET_OUT);
        end
        cyc();
        ptw_rsp_valid_i = 1'b1;
        ptw_rsp_ppn_i   = 22'h15555;
        cyc();
        ptw_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({miss_ready_o, entry_we_o, refill_done_o, refill_fault_o} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL rst_stray_rsp: got ready=%b we=%h done=%b fault=%b, required 1 00 0 0",
                     miss_ready_o, entry_we_o, refill_done_o, refill_fault_o);
        end
        cyc();
        last_we = '0;
        run_refill(9'h100, 20'h00001, 22'h00002, 1'b1, 8'hFF);
        n_checks++;
        if (last_we !== 8'h01) begin
            n_fails++;
            $display("FAIL rst_rr_cleared: got we=%h, required 01", last_we);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fails         = 0;
        rr_m            = 3'd0;
        last_we         = '0;
        rst_i           = 1'b1;
        tlb_flush_i     = 1'b0;
        miss_valid_i    = 1'b0;
        miss_asid_i     = '0;
        miss_vpn_i      = '0;
        ptw_req_ready_i = 1'b1;
        ptw_rsp_valid_i = 1'b0;
        ptw_rsp_fault_i = 1'b0;
        ptw_rsp_g_i     = 1'b0;
        ptw_rsp_ppn_i   = '0;
        entry_valid_i   = '0;

        test_reset();
        test_basic();
        test_victim_order();
        test_fault();
        test_backpressure();
        test_flush();
        test_reset_midwalk();

        cyc();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fails++;
            $display("FAIL sb_drained: got %0d pending writes, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
